riscv_multicycle_ctrl: RTL and testbench
========================================

# riscv_multicycle_ctrl

Moore-style control sequencer that converts the single-cycle RISC-V datapath into a multicycle machine sharing one memory port for instruction and data. It sits beside the datapath and decodes `opcode` from the instruction register. It drives every datapath strobe and mux select, waits on a memory ready handshake, and keeps cycle and retired-instruction counters. It supports R-type, I-ALU, lw, sw and beq; every other opcode traps.

## Interface

**Parameters**
- `CNT_W`, default 32: width of the performance counters.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `opcode` in 7: `ir[6:0]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completed the current read or write this cycle.
- `pcwrite` out 1: unconditional PC load.
- `pcwritecond` out 1: PC load qualified by `zero` in the datapath.
- `pcsource` out 1: selects the next PC. 0 selects the ALU result (PC+4); 1 selects ALUOut (branch target).
- `iord` out 1: memory address select. 0 selects PC; 1 selects ALUOut.
- `memread` out 1: memory read strobe.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: load the IR and the oldPC register.
- `regwrite` out 1: register file write.
- `memtoreg` out 1: writeback data select. 0 selects ALUOut; 1 selects MDR.
- `alusrca` out 2: ALU A select. 00 selects PC; 01 selects rs1; 10 selects oldPC.
- `alusrcb` out 2: ALU B select. 00 selects rs2; 01 selects constant 4; 10 selects ImmGen.
- `aluop` out 2: 00 add, 01 sub, 10 R-funct, 11 I-funct (funct7 ignored).
- `illegal` out 1: sticky trap flag.
- `cycle_cnt` out CNT_W: cycles since reset.
- `instret_cnt` out CNT_W: instructions retired.

## Operation

- State register is 4 bits. All outputs are decoded from the state. Outputs not listed for a state are 0.
- **FETCH**
  - Drives memread=1, iord=0, alusrca=00, alusrcb=01, aluop=00.
  - When mem_ready=1: drives irwrite=1, pcwrite=1, pcsource=0, and moves to DECODE.
  - When mem_ready=0: stays in FETCH.
- **DECODE**
  - Drives alusrca=10, alusrcb=10, aluop=00, so the branch target is latched into ALUOut.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEMADR
    - 1100011 → BRANCH
    - any other opcode → TRAP
- **MEMADR**: alusrca=01, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD**: memread=1, iord=1. Waits for mem_ready=1, then goes to MEMWB.
- **MEMWB**: regwrite=1, memtoreg=1. Goes to FETCH and retires.
- **MEMWR**: memwrite=1, iord=1. Waits for mem_ready=1, then goes to FETCH and retires.
- **EXEC_R**: alusrca=01, alusrcb=00, aluop=10. Goes to ALUWB.
- **EXEC_I**: alusrca=01, alusrcb=10, aluop=11. Goes to ALUWB.
- **ALUWB**: regwrite=1, memtoreg=0. Goes to FETCH and retires.
- **BRANCH**
  - Drives alusrca=01, alusrcb=00, aluop=01, pcwritecond=1, pcsource=1.
  - Goes to FETCH and retires whether or not the branch is taken.
- **TRAP**
  - Sets `illegal`=1. All strobes are 0.
  - Stays in TRAP until reset.
- **Counters**
  - `cycle_cnt` increments every cycle when not in TRAP.
  - `instret_cnt` increments on each retiring transition into FETCH.
  - Both wrap from all-ones to 0.

## Timing

- **Reset**
  - While `rst`=0, all strobe outputs are forced to 0 combinationally.
  - At the reset edge: state=FETCH, illegal=0, both counters=0.
- **Reset mid-operation**: reset in any state, including MEMRD or MEMWR with mem_ready pending, aborts the instruction. No retire is counted and no write strobe is issued.
- **Latency with zero-wait memory (mem_ready=1)**
  - R-type and I-ALU: 4 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- **Handshake**
  - memread and memwrite stay asserted and address-stable until the cycle in which mem_ready=1.
  - mem_ready is ignored in all other states.
- **Illegal opcode**: `illegal` rises one cycle after DECODE. No regwrite, memwrite or PC write occurs for that instruction.

## Structure

- **Shared package** `riscv_pkg`:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - the 11-entry state enum;
  - alusrca/alusrcb/aluop encodings, shared with the ALU control.
- **Sub-module** `perf_counter`: a CNT_W-bit counter with `en` and synchronous active-low reset, instantiated twice.

## Test plan

- **addi**: IR=0x00500113, mem_ready tied 1 → 4-cycle sequence FETCH, DECODE, EXEC_I, ALUWB; regwrite=1 in cycle 4; instret_cnt=1.
- **lw with wait states**: lw, mem_ready low for 2 cycles in MEMRD → memread=1 and iord=1 held for 3 cycles; completes in 7 cycles; memtoreg=1 together with regwrite.
- **beq**: beq with zero=1, then with zero=0 → pcwritecond=1 in cycle 3 both times; both retire in 3 cycles; instret_cnt increments by 2.
- **Illegal opcode**: opcode 0x7F → TRAP, illegal=1, no write strobes; cycle_cnt frozen for 10 cycles.
- **Reset during wait**: rst=0 while in MEMWR with mem_ready=0 → next state FETCH, memwrite=0, counters=0, illegal cleared.
- **Counter wrap**: CNT_W=4, 16 cycles of stalled FETCH → cycle_cnt wraps 15→0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, state and ALU-control encodings for the multicycle RISC-V core
package riscv_pkg;

  // Base opcodes handled by the multicycle sequencer
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // ALU operation class handed to the ALU control
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  // Sequencer states; 11 states fit in a 4-bit register
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  // Opcodes that go through the shared address-calculation state
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - enabled wrap-around counter with synchronous active-low reset
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up when enabled; all-ones wraps naturally to zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - multicycle RISC-V control sequencer with shared memory port and perf counters
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             pcsource,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memtoreg,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t state;
  state_t state_next;
  logic   retire;
  logic   cycle_en;

  // The branch decision is made in the datapath from pcwritecond and zero
  logic unused_zero;
  assign unused_zero = zero;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; strobes are forced low while reset is held
  always_comb begin
    state_next  = state;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = SRCA_PC;
    alusrcb     = SRCB_RS2;
    aluop       = ALUOP_ADD;
    retire      = 1'b0;

    case (state)
      S_FETCH: begin
        memread = 1'b1;
        iord    = 1'b0;
        alusrca = SRCA_PC;
        alusrcb = SRCB_FOUR;
        aluop   = ALUOP_ADD;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          pcsource   = 1'b0;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // oldPC + imm lands in ALUOut as the speculative branch target
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
        if (opcode == OP_R) begin
          state_next = S_EXEC_R;
        end else if (opcode == OP_IMM) begin
          state_next = S_EXEC_I;
        end else if (is_mem_op(opcode)) begin
          state_next = S_MEMADR;
        end else if (opcode == OP_BRANCH) begin
          state_next = S_BRANCH;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_ADD;
        state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_RFUNCT;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_IFUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b0;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = SRCA_RS1;
        alusrcb     = SRCB_RS2;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase

    // Reset aborts whatever is in flight: no strobes, no retire
    if (!rst) begin
      state_next  = S_FETCH;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      pcsource    = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regwrite    = 1'b0;
      memtoreg    = 1'b0;
      alusrca     = SRCA_PC;
      alusrcb     = SRCB_RS2;
      aluop       = ALUOP_ADD;
      retire      = 1'b0;
    end
  end

  // Sticky trap flag, raised together with the entry into TRAP
  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal <= 1'b0;
    end else if (state_next == S_TRAP) begin
      illegal <= 1'b1;
    end
  end

  // The machine is considered halted in TRAP, so cycles stop counting there
  assign cycle_en = (state != S_TRAP);

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cycle_en),
    .count (cycle_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (retire),
    .count (instret_cnt)
  );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - directed self-checking bench for the multicycle control sequencer
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pcwrite, pcwritecond, pcsource, iord, memread, memwrite;
  logic        irwrite, regwrite, memtoreg, illegal;
  logic [1:0]  alusrca, alusrcb, aluop;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        w_pcwrite, w_pcwritecond, w_pcsource, w_iord, w_memread, w_memwrite;
  logic        w_irwrite, w_regwrite, w_memtoreg, w_illegal;
  logic [1:0]  w_alusrca, w_alusrcb, w_aluop;
  logic [3:0]  w_cycle_cnt, w_instret_cnt;

  logic [14:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // Control word: pcwrite pcwritecond pcsource iord memread memwrite irwrite regwrite memtoreg | alusrca alusrcb aluop
  localparam logic [14:0] C_OFF        = 15'b0;
  localparam logic [14:0] C_FETCH_RDY  = {9'b1_0_0_0_1_0_1_0_0, 2'b00, 2'b01, 2'b00};
  localparam logic [14:0] C_FETCH_WAIT = {9'b0_0_0_0_1_0_0_0_0, 2'b00, 2'b01, 2'b00};
  localparam logic [14:0] C_DECODE     = {9'b0_0_0_0_0_0_0_0_0, 2'b10, 2'b10, 2'b00};
  localparam logic [14:0] C_MEMADR     = {9'b0_0_0_0_0_0_0_0_0, 2'b01, 2'b10, 2'b00};
  localparam logic [14:0] C_MEMRD      = {9'b0_0_0_1_1_0_0_0_0, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_MEMWB      = {9'b0_0_0_0_0_0_0_1_1, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_MEMWR      = {9'b0_0_0_1_0_1_0_0_0, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_EXEC_R     = {9'b0_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 2'b10};
  localparam logic [14:0] C_EXEC_I     = {9'b0_0_0_0_0_0_0_0_0, 2'b01, 2'b10, 2'b11};
  localparam logic [14:0] C_ALUWB      = {9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_BRANCH     = {9'b0_1_1_0_0_0_0_0_0, 2'b01, 2'b00, 2'b01};

  always #5 clk = ~clk;

  assign ctl = {pcwrite, pcwritecond, pcsource, iord, memread, memwrite, irwrite, regwrite, memtoreg,
                alusrca, alusrcb, aluop};

  riscv_multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .pcsource    (pcsource),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regwrite    (regwrite),
    .memtoreg    (memtoreg),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .illegal     (illegal),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  riscv_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pcwrite     (w_pcwrite),
    .pcwritecond (w_pcwritecond),
    .pcsource    (w_pcsource),
    .iord        (w_iord),
    .memread     (w_memread),
    .memwrite    (w_memwrite),
    .irwrite     (w_irwrite),
    .regwrite    (w_regwrite),
    .memtoreg    (w_memtoreg),
    .alusrca     (w_alusrca),
    .alusrcb     (w_alusrcb),
    .aluop       (w_aluop),
    .illegal     (w_illegal),
    .cycle_cnt   (w_cycle_cnt),
    .instret_cnt (w_instret_cnt)
  );

  // One reset edge; returns 1 time unit after it with rst released, in FETCH
  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; opcode = 7'h33; zero = 1'b0;
    @(posedge clk); #1;
    #1;
    n_checks++; if (ctl !== C_OFF) begin n_fail++; $display("FAIL reset_strobes got %b expected %b", ctl, C_OFF); end
    n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cycle_cnt got %0d expected 0", cycle_cnt); end
    n_checks++; if (instret_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_instret_cnt got %0d expected 0", instret_cnt); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b expected 0", illegal); end
    rst = 1'b1;
    #1;
    n_checks++; if (ctl !== C_FETCH_RDY) begin n_fail++; $display("FAIL reset_release_fetch got %b expected %b", ctl, C_FETCH_RDY); end
    @(posedge clk); #2;
    n_checks++; if (ctl !== C_DECODE) begin n_fail++; $display("FAIL reset_first_decode got %b expected %b", ctl, C_DECODE); end
    n_checks++; if (cycle_cnt !== 32'd1) begin n_fail++; $display("FAIL reset_first_cycle got %0d expected 1", cycle_cnt); end
  endtask

  task automatic test_addi();
    logic [14:0] exp [4];
    exp = '{C_FETCH_RDY, C_DECODE, C_EXEC_I, C_ALUWB};
    do_reset();
    opcode = 7'h13; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (ctl !== exp[i]) begin n_fail++; $display("FAIL addi_ctl cycle %0d got %b expected %b", i + 1, ctl, exp[i]); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (instret_cnt !== 32'd1) begin n_fail++; $display("FAIL addi_instret got %0d expected 1", instret_cnt); end
    n_checks++; if (cycle_cnt !== 32'd4) begin n_fail++; $display("FAIL addi_cycles got %0d expected 4", cycle_cnt); end
    n_checks++; if (ctl !== C_FETCH_RDY) begin n_fail++; $display("FAIL addi_back_to_fetch got %b expected %b", ctl, C_FETCH_RDY); end
  endtask

  task automatic test_lw_wait();
    logic [14:0] exp [7];
    logic        mr  [7];
    exp = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
    mr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    opcode = 7'h03;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      n_checks++; if (ctl !== exp[i]) begin n_fail++; $display("FAIL lw_ctl cycle %0d got %b expected %b", i + 1, ctl, exp[i]); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (instret_cnt !== 32'd1) begin n_fail++; $display("FAIL lw_instret got %0d expected 1", instret_cnt); end
    n_checks++; if (cycle_cnt !== 32'd7) begin n_fail++; $display("FAIL lw_cycles got %0d expected 7", cycle_cnt); end
  endtask

  task automatic test_beq();
    logic [14:0] exp [3];
    exp = '{C_FETCH_RDY, C_DECODE, C_BRANCH};
    do_reset();
    opcode = 7'h63; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      for (int i = 0; i < 3; i++) begin
        #1;
        n_checks++; if (ctl !== exp[i]) begin n_fail++; $display("FAIL beq%0d_ctl cycle %0d got %b expected %b", k, i + 1, ctl, exp[i]); end
        @(posedge clk); #1;
      end
    end
    #1;
    n_checks++; if (instret_cnt !== 32'd2) begin n_fail++; $display("FAIL beq_instret got %0d expected 2", instret_cnt); end
    n_checks++; if (cycle_cnt !== 32'd6) begin n_fail++; $display("FAIL beq_cycles got %0d expected 6", cycle_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp [8];
    logic [6:0]  op  [8];
    exp = '{C_FETCH_RDY, C_DECODE, C_EXEC_R, C_ALUWB, C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWR};
    op  = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h23, 7'h23, 7'h23, 7'h23};
    do_reset();
    mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      opcode = op[i];
      #1;
      n_checks++; if (ctl !== exp[i]) begin n_fail++; $display("FAIL b2b_ctl cycle %0d got %b expected %b", i + 1, ctl, exp[i]); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (instret_cnt !== 32'd2) begin n_fail++; $display("FAIL b2b_instret got %0d expected 2", instret_cnt); end
    n_checks++; if (cycle_cnt !== 32'd8) begin n_fail++; $display("FAIL b2b_cycles got %0d expected 8", cycle_cnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'h7f; mem_ready = 1'b1; zero = 1'b0;
    #1;
    n_checks++; if (ctl !== C_FETCH_RDY) begin n_fail++; $display("FAIL ill_fetch got %b expected %b", ctl, C_FETCH_RDY); end
    @(posedge clk); #2;
    n_checks++; if (ctl !== C_DECODE) begin n_fail++; $display("FAIL ill_decode got %b expected %b", ctl, C_DECODE); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_early got %b expected 0", illegal); end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag cycle %0d got %b expected 1", i, illegal); end
      n_checks++; if (ctl !== C_OFF) begin n_fail++; $display("FAIL ill_strobes cycle %0d got %b expected %b", i, ctl, C_OFF); end
      n_checks++; if (cycle_cnt !== 32'd2) begin n_fail++; $display("FAIL ill_cycle_frozen cycle %0d got %0d expected 2", i, cycle_cnt); end
      @(posedge clk); #1;
    end
    n_checks++; if (instret_cnt !== 32'd0) begin n_fail++; $display("FAIL ill_instret got %0d expected 0", instret_cnt); end
    do_reset();
    #1;
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_cleared got %b expected 0", illegal); end
    n_checks++; if (ctl !== C_FETCH_WAIT) begin n_fail++; $display("FAIL ill_refetch got %b expected %b", ctl, C_FETCH_WAIT); end
  endtask

  task automatic test_reset_wait();
    logic [14:0] exp [5];
    logic        mr  [5];
    exp = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    opcode = 7'h23; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      n_checks++; if (ctl !== exp[i]) begin n_fail++; $display("FAIL rstw_ctl cycle %0d got %b expected %b", i + 1, ctl, exp[i]); end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++; if (memwrite !== 1'b0) begin n_fail++; $display("FAIL rstw_memwrite_forced got %b expected 0", memwrite); end
    @(posedge clk); #2;
    n_checks++; if (ctl !== C_OFF) begin n_fail++; $display("FAIL rstw_strobes_held got %b expected %b", ctl, C_OFF); end
    n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL rstw_cycle_cnt got %0d expected 0", cycle_cnt); end
    n_checks++; if (instret_cnt !== 32'd0) begin n_fail++; $display("FAIL rstw_instret got %0d expected 0", instret_cnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (ctl !== C_FETCH_RDY) begin n_fail++; $display("FAIL rstw_fetch got %b expected %b", ctl, C_FETCH_RDY); end
  endtask

  task automatic test_counter_wrap();
    logic [3:0] e4;
    do_reset();
    mem_ready = 1'b0; opcode = 7'h33; zero = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #2;
      e4 = 4'(i % 16);
      n_checks++; if (w_cycle_cnt !== e4) begin n_fail++; $display("FAIL wrap_cycle4 after %0d got %0d expected %0d", i, w_cycle_cnt, e4); end
      n_checks++; if (ctl !== C_FETCH_WAIT) begin n_fail++; $display("FAIL wrap_stall_fetch after %0d got %b expected %b", i, ctl, C_FETCH_WAIT); end
    end
    n_checks++; if (cycle_cnt !== 32'd16) begin n_fail++; $display("FAIL wrap_cycle32 got %0d expected 16", cycle_cnt); end
    n_checks++; if (w_instret_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_instret4 got %0d expected 0", w_instret_cnt); end
  endtask

  initial begin
    rst = 1'b0; opcode = 7'h33; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_wait();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
